// File: rtl/dpram_fifo_ctrl.sv
// Single-clock FIFO controller driving one generic dual-port RAM as a 2^aw-entry circular buffer.
// Define DPRAM_FIFO_CTRL_ERR_EN to add sticky overflow/underflow flags with an err_clr input.
module dpram_fifo_ctrl #(
    parameter int aw = 5,
    parameter int dw = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [dw-1:0] push_data,
    output logic          full,
    input  logic          pop,
    output logic [dw-1:0] pop_data,
    output logic          pop_valid,
    output logic          empty,
    output logic [aw:0]   count,
    output logic          ram_rce,
    output logic          ram_oe,
    output logic [aw-1:0] ram_raddr,
    output logic          ram_wce,
    output logic          ram_we,
    output logic [aw-1:0] ram_waddr,
    output logic [dw-1:0] ram_di,
    input  logic [dw-1:0] ram_do
`ifdef DPRAM_FIFO_CTRL_ERR_EN
    ,
    input  logic          err_clr,
    output logic          ovf,
    output logic          udf
`endif
);

    localparam logic [aw:0] depth   = {1'b1, {aw{1'b0}}};
    localparam logic [aw:0] count_1 = {{aw{1'b0}}, 1'b1};

    logic [aw-1:0] wptr;
    logic [aw-1:0] rptr;
    logic          rd_pending;
    logic          push_acc;
    logic          pop_acc;

    assign empty    = (count == '0);
    assign full     = (count == depth);
    assign push_acc = push & ~full;
    assign pop_acc  = pop & ~empty;

    // The RAM flags collisions from we alone, so we must only follow an accepted push.
    assign ram_wce   = push_acc;
    assign ram_we    = push_acc;
    assign ram_waddr = wptr;
    assign ram_di    = push_data;

    // rce stays high in the cycle after the pop so the RAM keeps driving ram_do.
    assign ram_raddr = rptr;
    assign ram_rce   = pop_acc | rd_pending;
    assign ram_oe    = rd_pending;
    assign pop_valid = rd_pending;
    assign pop_data  = ram_do;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr       <= '0;
            rptr       <= '0;
            count      <= '0;
            rd_pending <= 1'b0;
        end else begin
            wptr       <= wptr + aw'(push_acc);
            rptr       <= rptr + aw'(pop_acc);
            rd_pending <= pop_acc;
            case ({push_acc, pop_acc})
                2'b10:   count <= count + count_1;
                2'b01:   count <= count - count_1;
                default: count <= count;
            endcase
        end
    end

`ifdef DPRAM_FIFO_CTRL_ERR_EN
    // Sticky error flags; a new error in the same cycle as err_clr keeps the flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
            udf <= 1'b0;
        end else begin
            if (push & full)
                ovf <= 1'b1;
            else if (err_clr)
                ovf <= 1'b0;
            if (pop & empty)
                udf <= 1'b1;
            else if (err_clr)
                udf <= 1'b0;
        end
    end
`else
    // Requests while full or empty are dropped without any record.
`endif

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Self-checking bench for dpram_fifo_ctrl with a behavioural dual-port RAM and a data scoreboard.
// Build with DPRAM_FIFO_CTRL_ERR_EN defined to also exercise the sticky error flags.
module tb_dpram_fifo_ctrl;

    localparam int aw    = 5;
    localparam int dw    = 16;
    localparam int depth = 1 << aw;

    logic          clk = 1'b0;
    logic          rst;
    logic          push;
    logic [dw-1:0] push_data;
    logic          full;
    logic          pop;
    logic [dw-1:0] pop_data;
    logic          pop_valid;
    logic          empty;
    logic [aw:0]   count;
    logic          ram_rce;
    logic          ram_oe;
    logic [aw-1:0] ram_raddr;
    logic          ram_wce;
    logic          ram_we;
    logic [aw-1:0] ram_waddr;
    logic [dw-1:0] ram_di;
    logic [dw-1:0] ram_do;
`ifdef DPRAM_FIFO_CTRL_ERR_EN
    logic          err_clr;
    logic          ovf;
    logic          udf;
`endif

    int checks = 0;
    int errors = 0;
    int valid_seen = 0;
    bit mon_en = 1'b0;

    always #5 clk = ~clk;

    dpram_fifo_ctrl #(.aw(aw), .dw(dw)) dut (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .full      (full),
        .pop       (pop),
        .pop_data  (pop_data),
        .pop_valid (pop_valid),
        .empty     (empty),
        .count     (count),
        .ram_rce   (ram_rce),
        .ram_oe    (ram_oe),
        .ram_raddr (ram_raddr),
        .ram_wce   (ram_wce),
        .ram_we    (ram_we),
        .ram_waddr (ram_waddr),
        .ram_di    (ram_di),
        .ram_do    (ram_do)
`ifdef DPRAM_FIFO_CTRL_ERR_EN
        ,
        .err_clr   (err_clr),
        .ovf       (ovf),
        .udf       (udf)
`endif
    );

    // Behavioural RAM: registered read, sentinels stand in for a collision X and an undriven Z bus.
    logic [dw-1:0] mem [depth];
    logic [dw-1:0] ram_q = '0;

    always @(posedge clk) begin
        if (ram_wce && ram_we)
            mem[ram_waddr] <= ram_di;
        if (ram_rce)
            ram_q <= (ram_wce && ram_we && ram_raddr == ram_waddr) ? 16'hBAD0 : mem[ram_raddr];
    end

    assign ram_do = (ram_rce && ram_oe) ? ram_q : 16'hDEAD;

    // Reference model and scoreboard, updated from the stimulus alone.
    logic [dw-1:0] sb[$];
    int            m_count = 0;
    logic [aw-1:0] m_wptr = '0;
    bit            m_pending = 1'b0;
    logic [dw-1:0] m_exp = '0;
    bit            m_push_acc;
    bit            m_pop_acc;

    always @(posedge clk) begin
        m_push_acc = push && (m_count < depth);
        m_pop_acc  = pop && (m_count > 0);
        if (rst) begin
            m_count   = 0;
            m_wptr    = '0;
            m_pending = 1'b0;
            sb.delete();
        end else begin
            if (m_push_acc) begin
                sb.push_back(push_data);
                m_wptr = m_wptr + 1'b1;
            end
            if (m_pop_acc)
                m_exp = sb.pop_front();
            m_pending = m_pop_acc;
            m_count   = m_count + int'(m_push_acc) - int'(m_pop_acc);
        end
    end

    // Continuous mid-cycle comparison of outputs against the model.
    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if (pop_valid !== m_pending) begin
                errors++;
                $display("FAIL mon_pop_valid t=%0t got %b exp %b", $time, pop_valid, m_pending);
            end
            if (m_pending) begin
                valid_seen++;
                checks++;
                if (pop_data !== m_exp) begin
                    errors++;
                    $display("FAIL mon_pop_data t=%0t got %h exp %h", $time, pop_data, m_exp);
                end
            end
            checks++;
            if (count !== (aw+1)'(m_count)) begin
                errors++;
                $display("FAIL mon_count t=%0t got %0d exp %0d", $time, count, m_count);
            end
            checks++;
            if (empty !== (m_count == 0) || full !== (m_count == depth)) begin
                errors++;
                $display("FAIL mon_flags t=%0t got empty=%b full=%b exp count=%0d", $time, empty, full, m_count);
            end
            checks++;
            if (ram_we !== (push && m_count < depth)) begin
                errors++;
                $display("FAIL mon_ram_we t=%0t got %b exp %b", $time, ram_we, push && m_count < depth);
            end
            if (ram_we === 1'b1) begin
                checks++;
                if (ram_waddr !== m_wptr) begin
                    errors++;
                    $display("FAIL mon_ram_waddr t=%0t got %0d exp %0d", $time, ram_waddr, m_wptr);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        mon_en = 1'b1;
        checks++;
        if (empty !== 1'b1 || full !== 1'b0 || pop_valid !== 1'b0 || count !== '0) begin
            errors++;
            $display("FAIL reset_state got empty=%b full=%b pop_valid=%b count=%0d exp 1 0 0 0",
                     empty, full, pop_valid, count);
        end
        rst = 1'b0;
    endtask

    task automatic test_fill();
        for (int i = 1; i <= depth; i++) begin
            push = 1'b1;
            push_data = dw'(i);
            tick();
        end
        push = 1'b0;
        checks++;
        if (full !== 1'b1 || count !== (aw+1)'(depth)) begin
            errors++;
            $display("FAIL fill_full got full=%b count=%0d exp 1 %0d", full, count, depth);
        end
        push = 1'b1;
        push_data = 16'h0033;
        #1;
        checks++;
        if (ram_we !== 1'b0) begin
            errors++;
            $display("FAIL push_when_full_we got %b exp 0", ram_we);
        end
        tick();
        push = 1'b0;
        checks++;
        if (count !== (aw+1)'(depth)) begin
            errors++;
            $display("FAIL push_when_full_count got %0d exp %0d", count, depth);
        end
    endtask

    task automatic test_drain();
        int seen0 = valid_seen;
        pop = 1'b1;
        tick();
        checks++;
        if (pop_valid !== 1'b1 || pop_data !== 16'h0001) begin
            errors++;
            $display("FAIL drain_first got valid=%b data=%h exp 1 0001", pop_valid, pop_data);
        end
        repeat (depth - 1) tick();
        pop = 1'b0;
        repeat (2) tick();
        checks++;
        if (valid_seen - seen0 != depth || empty !== 1'b1) begin
            errors++;
            $display("FAIL drain_total got words=%0d empty=%b exp %0d 1", valid_seen - seen0, empty, depth);
        end
    endtask

    task automatic test_push_pop_empty();
        push = 1'b1;
        pop = 1'b1;
        push_data = 16'hA5A5;
        tick();
        push = 1'b0;
        pop = 1'b0;
        checks++;
        if (count !== (aw+1)'(1) || pop_valid !== 1'b0) begin
            errors++;
            $display("FAIL pushpop_empty got count=%0d valid=%b exp 1 0", count, pop_valid);
        end
        pop = 1'b1;
        tick();
        pop = 1'b0;
        checks++;
        if (pop_valid !== 1'b1 || pop_data !== 16'hA5A5) begin
            errors++;
            $display("FAIL pushpop_readback got valid=%b data=%h exp 1 a5a5", pop_valid, pop_data);
        end
        tick();
        checks++;
        if (empty !== 1'b1) begin
            errors++;
            $display("FAIL pushpop_empty_after got %b exp 1", empty);
        end
    endtask

    task automatic test_wrap();
        int seen0 = valid_seen;
        for (int i = 0; i < 16; i++) begin
            push = 1'b1;
            push_data = 16'h1000 + dw'(i);
            tick();
        end
        for (int i = 16; i < 56; i++) begin
            push = 1'b1;
            pop = 1'b1;
            push_data = 16'h1000 + dw'(i);
            tick();
        end
        push = 1'b0;
        pop = 1'b0;
        checks++;
        if (count !== (aw+1)'(16)) begin
            errors++;
            $display("FAIL wrap_count got %0d exp 16", count);
        end
        pop = 1'b1;
        repeat (16) tick();
        pop = 1'b0;
        repeat (2) tick();
        checks++;
        if (valid_seen - seen0 != 56 || empty !== 1'b1) begin
            errors++;
            $display("FAIL wrap_total got words=%0d empty=%b exp 56 1", valid_seen - seen0, empty);
        end
    endtask

    task automatic test_reset_mid_read();
        for (int i = 0; i < 2; i++) begin
            push = 1'b1;
            push_data = 16'h7700 + dw'(i);
            tick();
        end
        push = 1'b0;
        pop = 1'b1;
        tick();
        pop = 1'b0;
        rst = 1'b1;
        checks++;
        if (pop_valid !== 1'b1) begin
            errors++;
            $display("FAIL midread_valid got %b exp 1", pop_valid);
        end
        tick();
        rst = 1'b0;
        checks++;
        if (pop_valid !== 1'b0 || count !== '0 || empty !== 1'b1) begin
            errors++;
            $display("FAIL midread_reset got valid=%b count=%0d empty=%b exp 0 0 1", pop_valid, count, empty);
        end
    endtask

`ifdef DPRAM_FIFO_CTRL_ERR_EN
    task automatic test_err_flags();
        checks++;
        if (ovf !== 1'b0 || udf !== 1'b0) begin
            errors++;
            $display("FAIL err_reset got ovf=%b udf=%b exp 0 0", ovf, udf);
        end
        pop = 1'b1;
        tick();
        pop = 1'b0;
        repeat (3) tick();
        checks++;
        if (udf !== 1'b1) begin
            errors++;
            $display("FAIL udf_sticky got %b exp 1", udf);
        end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checks++;
        if (udf !== 1'b0) begin
            errors++;
            $display("FAIL udf_clear got %b exp 0", udf);
        end
        pop = 1'b1;
        err_clr = 1'b1;
        tick();
        pop = 1'b0;
        err_clr = 1'b0;
        checks++;
        if (udf !== 1'b1) begin
            errors++;
            $display("FAIL udf_set_wins got %b exp 1", udf);
        end
        for (int i = 0; i <= depth; i++) begin
            push = 1'b1;
            push_data = 16'h2000 + dw'(i);
            tick();
        end
        push = 1'b0;
        checks++;
        if (ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set got %b exp 1", ovf);
        end
    endtask
`endif

    initial begin
        rst = 1'b1;
        push = 1'b0;
        pop = 1'b0;
        push_data = '0;
`ifdef DPRAM_FIFO_CTRL_ERR_EN
        err_clr = 1'b0;
`endif
        #1;
        test_reset();
        test_fill();
        test_drain();
        test_push_pop_empty();
        test_wrap();
        test_reset_mid_read();
`ifdef DPRAM_FIFO_CTRL_ERR_EN
        test_err_flags();
`endif
        repeat (2) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
